eca_row_engine: RTL and testbench
=================================

ECA_ROW_ENGINE -- requirements
Module: eca_row_engine

Interface
REQ-001 Parameter CELLS, default 320, number of cells per row (2..1024).
REQ-002 Parameter CELL_SHIFT, default 1, log2 of pixels per cell horizontally.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, reset value of the seed LFSR.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 video_active  input  1  high during visible pixels.
REQ-007 pix_x  input  10  current pixel column.
REQ-008 pix_y  input  10  current pixel row.
REQ-009 rule_in  input  8  Wolfram elementary rule number.
REQ-010 wrap_en  input  1  1 = circular boundary, 0 = zero boundary.
REQ-011 seed_mode  input  1  0 = single centre cell, 1 = LFSR random row.
REQ-012 hold  input  1  1 = freeze evolution (repeat current generation).
REQ-013 cell_out  output  1  cell state for the pixel presented one cycle earlier.

Function
REQ-014 Cell index c = pix_x >> CELL_SHIFT; a cell step occurs on a cycle with video_active=1, pix_x[CELL_SHIFT-1:0] all ones, and c < CELLS.
REQ-015 Row storage is CELLS bits; exactly CELLS cell steps per visible line consume the current generation and produce the next.
REQ-016 Frame latch: at video_active & pix_y==0 & pix_x==0, rule_in, wrap_en and seed_mode are captured; they are constant for the rest of the frame.
REQ-017 Row 0 (pix_y==0): displayed value and stored value of cell c is the seed: seed_mode=0 -> 1 iff c==CELLS/2; seed_mode=1 -> LFSR bit 0.
REQ-018 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances once per cell step on row 0 only; never reseeded except by reset.
REQ-019 Rows pix_y>=1: new cell c = rule[{L,C,R}] where L,C,R are cells c-1,c,c+1 of the previous generation; index 0..7 with L as MSB.
REQ-020 Boundary: for c=0, L = wrap_en ? cell CELLS-1 : 0; for c=CELLS-1, R = wrap_en ? cell 0 : 0; both use previous-generation values.
REQ-021 Displayed value on row y>=1 is the newly computed generation; one generation per visible line.
REQ-022 hold sampled at pix_y==0/pix_x==0 is ignored; hold captured at each line start (pix_x==0, video_active) applies to the whole line; when held, the stored row recirculates unchanged and is redisplayed.
REQ-023 Row 0 with hold=1 still loads the seed.
REQ-024 cell_out = registered value, 1 clk after the coordinates; 0 when video_active was 0 or c >= CELLS in that cycle.
REQ-025 No cell step outside visible area; row storage holds across blanking unchanged.
REQ-026 Rule change mid-frame has no effect until the next frame latch.

Reset
REQ-027 On reset: row storage all 0, LFSR = LFSR_SEED, latched rule = 8'd0, latched wrap_en=0, seed_mode=0, hold=0, cell_out=0.
REQ-028 Reset asserted mid-frame: outputs 0 next cycle; after release, rows render 0 until the next pix_y==0 row loads a seed.

Structure
REQ-029 Shared package holds: default CELLS, CELL_SHIFT, LFSR_SEED, LFSR tap mask, rule-index bit ordering constant.
REQ-030 One sub-module, eca_lfsr16 (enable, reset, 16-bit state, bit0 output); neighbourhood lookup stays inline.

Verification
REQ-031 rule 90, seed_mode=0, wrap_en=0, CELLS=320 -> row 1 cells 159,161 = 1, all else 0; row 2 cells 158,162 = 1.
REQ-032 rule 204 (identity), seed_mode=1 -> every row 1..479 equals row 0 bit for bit.
REQ-033 rule 170 (new=R), single seed moved to cell 0 via CELLS=2-cell bench, wrap_en=1 -> row 1 cell CELLS-1 = 1; wrap_en=0 -> row 1 all 0.
REQ-034 rule 30 running, hold=1 for lines 10..19 -> lines 10..19 identical to line 9; line 20 equals golden model generation 10.
REQ-035 rule_in changed from 30 to 110 at pix_y=100 -> frame unaffected; next frame matches rule 110 golden model.
REQ-036 reset pulsed at pix_y=200 -> cell_out 0 until next frame; next frame row 0 matches seed with LFSR restarted at 16'hACE1.

Source files
------------

// File: rtl/eca_row_engine_pkg.sv
// Shared constants and helpers for the elementary cellular automaton row engine.
// Latency: none; definitions only.
// Backpressure: none; definitions only.
package eca_row_engine_pkg;

  localparam int          ECA_CELLS_DEF      = 320;
  localparam int          ECA_CELL_SHIFT_DEF = 1;
  localparam logic [15:0] ECA_LFSR_SEED_DEF  = 16'hACE1;

  // Right-shifting Fibonacci form: polynomial taps 16,14,13,11 sit on state bits 0,2,3,5.
  localparam logic [15:0] ECA_LFSR_TAPS      = 16'h002D;

  // Position of each neighbour inside the 3-bit Wolfram rule index (left cell is the MSB).
  localparam int RULE_IDX_L = 2;
  localparam int RULE_IDX_C = 1;
  localparam int RULE_IDX_R = 0;

  function automatic logic [2:0] rule_index(input logic l, input logic c, input logic r);
    logic [2:0] idx;
    idx             = '0;
    idx[RULE_IDX_L] = l;
    idx[RULE_IDX_C] = c;
    idx[RULE_IDX_R] = r;
    return idx;
  endfunction

endpackage

// File: rtl/eca_lfsr16.sv
// 16-bit Fibonacci LFSR supplying the random seed row, one bit per enabled cycle.
// Latency: bit0 reflects the current state; the state advances on the clock after enable.
// Backpressure: none; holds its state while enable is low.
module eca_lfsr16
  import eca_row_engine_pkg::*;
#(
  parameter logic [15:0] SEED = ECA_LFSR_SEED_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit0
);

  logic [15:0] state;
  logic        feedback;

  assign feedback = ^(state & ECA_LFSR_TAPS);
  assign bit0     = state[0];

  // Shift right, feeding the tap parity into the top bit; only reset reseeds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (enable) begin
      state <= {feedback, state[15:1]};
    end
  end

endmodule

// File: rtl/eca_row_engine.sv
// Renders one elementary CA generation per visible line from a CELLS-bit row store.
// Latency: cell_out is registered, one clock after the pixel coordinates.
// Backpressure: none; follows the video timing, and nothing evolves during blanking.
module eca_row_engine
  import eca_row_engine_pkg::*;
#(
  parameter int          CELLS      = ECA_CELLS_DEF,
  parameter int          CELL_SHIFT = ECA_CELL_SHIFT_DEF,
  parameter logic [15:0] LFSR_SEED  = ECA_LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [7:0] rule_in,
  input  logic       wrap_en,
  input  logic       seed_mode,
  input  logic       hold,
  output logic       cell_out
);

  localparam int             IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [9:0]     PIX_MASK = 10'((1 << CELL_SHIFT) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(CELLS / 2);

  // Row store: generation being displayed, updated in place one cell per step.
  logic [CELLS-1:0] row_q;
  // Old value of cell c-1 (already overwritten) and old value of cell 0 for the right wrap.
  logic             prev_old_q;
  logic             first_old_q;

  logic [7:0]       rule_q;
  logic             wrap_q;
  logic             seed_mode_q;
  logic             hold_q;

  logic [9:0]       cell_x;
  logic             in_row;
  logic             row0;
  logic             frame_start;
  logic             line_start;
  logic             step;
  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] idx_r;
  logic             seed_mode_eff;
  logic             hold_eff;
  logic             lfsr_bit;
  logic             seed_bit;
  logic             nb_l;
  logic             nb_c;
  logic             nb_r;
  logic             evolved;
  logic             cell_val;

  assign cell_x      = pix_x >> CELL_SHIFT;
  assign in_row      = ({1'b0, cell_x} < 11'(CELLS));
  assign row0        = (pix_y == 10'd0);
  assign frame_start = video_active & row0 & (pix_x == 10'd0);
  assign line_start  = video_active & (pix_x == 10'd0);
  assign step        = video_active & ((pix_x & PIX_MASK) == PIX_MASK) & in_row;

  assign idx_c = in_row ? cell_x[IDX_W-1:0] : '0;
  assign idx_r = (idx_c == LAST_IDX) ? '0 : idx_c + 1'b1;

  // The capture cycle itself already displays, so it must see the incoming values.
  assign seed_mode_eff = frame_start ? seed_mode : seed_mode_q;
  assign hold_eff      = line_start ? hold : hold_q;

  // Cells below c were rewritten this line, so the left neighbour comes from prev_old_q;
  // cell 0 has already been rewritten when the last cell needs it, hence first_old_q.
  assign nb_l = (idx_c == '0) ? (wrap_q & row_q[LAST_IDX]) : prev_old_q;
  assign nb_c = row_q[idx_c];
  assign nb_r = (idx_c == LAST_IDX) ? (wrap_q & first_old_q) : row_q[idx_r];

  assign evolved  = rule_q[rule_index(nb_l, nb_c, nb_r)];
  assign seed_bit = seed_mode_eff ? lfsr_bit : (idx_c == MID_IDX);
  assign cell_val = row0 ? seed_bit : (hold_eff ? nb_c : evolved);

  eca_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .enable(step & row0),
    .bit0  (lfsr_bit)
  );

  // Capture the per-frame controls on the first visible pixel of row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rule_q      <= 8'd0;
      wrap_q      <= 1'b0;
      seed_mode_q <= 1'b0;
    end else if (frame_start) begin
      rule_q      <= rule_in;
      wrap_q      <= wrap_en;
      seed_mode_q <= seed_mode;
    end
  end

  // Capture hold at each line start; row 0 always seeds, so its hold is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else if (line_start) begin
      hold_q <= hold & ~row0;
    end
  end

  // Write the displayed value back on the last pixel of each cell, keeping old neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      prev_old_q  <= 1'b0;
      first_old_q <= 1'b0;
    end else if (step) begin
      row_q[idx_c] <= cell_val;
      prev_old_q   <= nb_c;
      if (idx_c == '0) begin
        first_old_q <= nb_c;
      end
    end
  end

  // Register the pixel output, blanking outside the visible cell range.
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_out <= 1'b0;
    end else begin
      cell_out <= video_active & in_row & cell_val;
    end
  end

endmodule

// File: tb/tb_eca_row_engine.sv
// Directed frame-level bench with a generation-at-a-time reference model.
// Latency: expects cell_out one clock after each driven coordinate.
// Backpressure: none.
module tb_eca_row_engine;

  localparam int CELLS      = 20;
  localparam int CELL_SHIFT = 1;
  localparam int VIS_W      = 48;   // cells 20..23 are visible but outside the row
  localparam int LINE_LEN   = 54;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] rule_in;
  logic       wrap_en;
  logic       seed_mode;
  logic       hold;
  logic       cell_out;

  always #5 clk = ~clk;

  eca_row_engine #(
    .CELLS     (CELLS),
    .CELL_SHIFT(CELL_SHIFT),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .video_active(video_active),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .rule_in     (rule_in),
    .wrap_en     (wrap_en),
    .seed_mode   (seed_mode),
    .hold        (hold),
    .cell_out    (cell_out)
  );

  int n_vec;
  int n_err;

  // Reference model: whole generations as bit vectors.
  logic [CELLS-1:0] m_gen;
  logic [CELLS-1:0] m_line;
  logic [15:0]      m_lfsr;
  logic [7:0]       m_rule;
  logic             m_wrap;
  logic             m_seed;

  // Expectation for the coordinates driven one cycle earlier.
  logic exp_prev;
  logic chk_prev;
  logic vis_prev;
  int   c_prev;
  int   y_prev;

  logic [CELLS-1:0] dut_rows [0:255];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int fb;
    fb = ((int'(s) >> 0) ^ (int'(s) >> 2) ^ (int'(s) >> 3) ^ (int'(s) >> 5)) & 1;
    return 16'((int'(s) >> 1) | (fb << 15));
  endfunction

  function automatic logic [CELLS-1:0] next_gen(input logic [CELLS-1:0] g, input logic [7:0] rule,
                                                input logic wrap);
    logic [CELLS-1:0] n;
    int l;
    int ce;
    int r;
    n = '0;
    for (int c = 0; c < CELLS; c++) begin
      if (c == 0) l = (wrap && g[CELLS-1]) ? 1 : 0;
      else        l = g[c-1] ? 1 : 0;
      ce = g[c] ? 1 : 0;
      if (c == CELLS - 1) r = (wrap && g[0]) ? 1 : 0;
      else                r = g[c+1] ? 1 : 0;
      n[c] = rule[l * 4 + ce * 2 + r];
    end
    return n;
  endfunction

  task automatic model_reset();
    m_gen  = '0;
    m_line = '0;
    m_lfsr = 16'hACE1;
    m_rule = 8'd0;
    m_wrap = 1'b0;
    m_seed = 1'b0;
  endtask

  task automatic check_vec(input string name, input logic [CELLS-1:0] got, input logic [CELLS-1:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Per-cycle comparison of cell_out against the model's expectation.
  task automatic compare_cycle();
    if (chk_prev) begin
      n_vec++;
      if (cell_out !== exp_prev) begin
        n_err++;
        $display("FAIL cell_out y=%0d c=%0d: got %b, expected %b", y_prev, c_prev, cell_out, exp_prev);
      end
      if (vis_prev && c_prev < CELLS && y_prev < 256) dut_rows[y_prev][c_prev] = cell_out;
    end
  endtask

  task automatic tick(input logic vis, input int x, input int y, input logic rst);
    @(posedge clk);
    #1;
    compare_cycle();
    video_active = vis;
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    reset        = rst;
    if (rst) begin
      model_reset();
      exp_prev = 1'b0;
    end else begin
      exp_prev = (vis && (x >> CELL_SHIFT) < CELLS) ? m_line[x >> CELL_SHIFT] : 1'b0;
    end
    c_prev   = x >> CELL_SHIFT;
    vis_prev = vis;
    y_prev   = y;
    chk_prev = 1'b1;
  endtask

  task automatic drive_line(input int y, input logic vis, input logic hold_v, input int rst_at);
    hold = hold_v;
    if (vis) begin
      if (y == 0) begin
        m_rule = rule_in;
        m_wrap = wrap_en;
        m_seed = seed_mode;
        for (int c = 0; c < CELLS; c++) begin
          m_line[c] = m_seed ? m_lfsr[0] : (c == CELLS / 2);
          m_lfsr    = lfsr_next(m_lfsr);
        end
        m_gen = m_line;
      end else if (!hold_v) begin
        m_gen  = next_gen(m_gen, m_rule, m_wrap);
        m_line = m_gen;
      end else begin
        m_line = m_gen;
      end
    end
    for (int x = 0; x < LINE_LEN; x++) begin
      tick(vis && x < VIS_W, x, y, rst_at >= 0 && x >= rst_at && x < rst_at + 3);
    end
  endtask

  task automatic run_frame(input int nlines, input logic [7:0] rule, input logic wrap, input logic seed,
                           input int hold_lo, input int hold_hi, input int rule2_at,
                           input logic [7:0] rule2, input int rst_line);
    rule_in   = rule;
    wrap_en   = wrap;
    seed_mode = seed;
    for (int y = 0; y < nlines; y++) begin
      if (y == rule2_at) rule_in = rule2;
      drive_line(y, 1'b1, hold_lo >= 0 && (y == 0 || (y >= hold_lo && y <= hold_hi)),
                 (y == rst_line) ? 10 : -1);
    end
    for (int y = 0; y < 2; y++) drive_line(nlines + y, 1'b0, 1'b0, -1);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    chk_prev     = 1'b0;
    vis_prev     = 1'b0;
    exp_prev     = 1'b0;
    c_prev       = 0;
    y_prev       = 0;
    reset        = 1'b1;
    video_active = 1'b0;
    pix_x        = '0;
    pix_y        = '0;
    rule_in      = 8'd0;
    wrap_en      = 1'b0;
    seed_mode    = 1'b0;
    hold         = 1'b0;
    model_reset();

    for (int i = 0; i < 4; i++) tick(1'b0, i, 500, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, i, 500, 1'b0);
    check_vec("reset cell_out", CELLS'(cell_out), '0);

    // Rule 90 from the centre seed, zero boundary.
    run_frame(8, 8'd90, 1'b0, 1'b0, -1, -1, -1, 8'd0, -1);
    check_vec("r90 row0", dut_rows[0], 20'h00400);
    check_vec("r90 row1", dut_rows[1], 20'h00A00);
    check_vec("r90 row2", dut_rows[2], 20'h01100);

    // Rule 204 keeps the random seed row unchanged.
    run_frame(20, 8'd204, 1'b1, 1'b1, -1, -1, -1, 8'd0, -1);
    for (int y = 1; y < 20; y++) check_vec($sformatf("r204 row%0d", y), dut_rows[y], dut_rows[0]);

    // Rule 170 walks the seed left into cell 0, then across the boundary.
    run_frame(14, 8'd170, 1'b1, 1'b0, -1, -1, -1, 8'd0, -1);
    check_vec("r170 wrap row10", dut_rows[10], 20'h00001);
    check_vec("r170 wrap row11", dut_rows[11], 20'h80000);
    run_frame(14, 8'd170, 1'b0, 1'b0, -1, -1, -1, 8'd0, -1);
    check_vec("r170 zero row10", dut_rows[10], 20'h00001);
    check_vec("r170 zero row11", dut_rows[11], 20'h00000);

    // Rule 30 with hold on row 0 (ignored) and on lines 10..19.
    run_frame(24, 8'd30, 1'b1, 1'b0, 10, 19, -1, 8'd0, -1);
    check_vec("hold row0 seeded", dut_rows[0], 20'h00400);
    check_vec("r30 row1", dut_rows[1], 20'h00E00);
    for (int y = 10; y < 20; y++) check_vec($sformatf("held row%0d", y), dut_rows[y], dut_rows[9]);

    // Rule input switches to 110 mid-frame; only the next frame follows it.
    run_frame(110, 8'd30, 1'b1, 1'b0, -1, -1, 100, 8'd110, -1);
    check_vec("midframe rule row1", dut_rows[1], 20'h00E00);
    run_frame(20, 8'd110, 1'b1, 1'b0, -1, -1, -1, 8'd0, -1);
    check_vec("r110 row1", dut_rows[1], 20'h00600);

    // Reset pulsed on line 200; the rest of the frame must stay dark.
    run_frame(210, 8'd30, 1'b1, 1'b0, -1, -1, -1, 8'd0, 200);
    for (int y = 201; y < 210; y++) check_vec($sformatf("post-reset row%0d", y), dut_rows[y], '0);

    // LFSR restarts at ACE1: first six seed bits are 1,0,0,0,0,1.
    run_frame(6, 8'd204, 1'b0, 1'b1, -1, -1, -1, 8'd0, -1);
    check_vec("lfsr restart seed", dut_rows[0] & 20'h0003F, 20'h00021);
    check_vec("lfsr restart row1", dut_rows[1], dut_rows[0]);

    tick(1'b0, 0, 500, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
